// File: rtl/pipe_reg_e_pkg.sv
// Shared constants and update-select helper for the decode->execute register.
// The same NOP encoding is reused by the decode/memory stage registers.
package pipe_reg_e_pkg;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  localparam int LSI_LB  = 7;
  localparam int LSI_LH  = 6;
  localparam int LSI_LW  = 5;
  localparam int LSI_LBU = 4;
  localparam int LSI_LHU = 3;
  localparam int LSI_SB  = 2;
  localparam int LSI_SH  = 1;
  localparam int LSI_SW  = 0;

  typedef enum logic [1:0] {
    UPD_NOP,
    UPD_HOLD,
    UPD_LOAD
  } upd_e;

  // rst > bubble > stall > load; an invalid load collapses to a NOP
  function automatic upd_e upd_sel(
    input logic rst,
    input logic bubble,
    input logic stall,
    input logic valid
  );
    upd_e u;
    if (rst || bubble) u = UPD_NOP;
    else if (stall) u = UPD_HOLD;
    else if (!valid) u = UPD_NOP;
    else u = UPD_LOAD;
    return u;
  endfunction

endpackage

// File: rtl/pipe_reg_e_if.sv
// Decode->execute bundle: decode fields in, registered regE fields out.
// Counter ports are always present; they read 0 unless PIPE_PERF_CNT_EN.
interface pipe_reg_e_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic            ctrl_i_regE_stall;
  logic            ctrl_i_regE_bubble;

  logic            decode_i_valid;
  logic [XLEN-1:0] decode_i_pc;
  logic [31:0]     decode_i_instr;
  logic [4:0]      decode_i_rs1;
  logic [4:0]      decode_i_rs2;
  logic [4:0]      decode_i_rd;
  logic            decode_i_reg_wen;
  logic [XLEN-1:0] decode_i_imm;
  logic [7:0]      decode_i_load_store_info;

  logic            regE_o_valid;
  logic [XLEN-1:0] regE_o_pc;
  logic [31:0]     regE_o_instr;
  logic [4:0]      regE_o_rs1;
  logic [4:0]      regE_o_rs2;
  logic [4:0]      regE_o_rd;
  logic            regE_o_reg_wen;
  logic [XLEN-1:0] regE_o_imm;
  logic [7:0]      regE_o_load_store_info;

  logic [CNT_W-1:0] regE_o_stall_cnt;
  logic [CNT_W-1:0] regE_o_bubble_cnt;
  logic [CNT_W-1:0] regE_o_issue_cnt;

  modport master (
    output ctrl_i_regE_stall,
    output ctrl_i_regE_bubble,
    output decode_i_valid,
    output decode_i_pc,
    output decode_i_instr,
    output decode_i_rs1,
    output decode_i_rs2,
    output decode_i_rd,
    output decode_i_reg_wen,
    output decode_i_imm,
    output decode_i_load_store_info,
    input  regE_o_valid,
    input  regE_o_pc,
    input  regE_o_instr,
    input  regE_o_rs1,
    input  regE_o_rs2,
    input  regE_o_rd,
    input  regE_o_reg_wen,
    input  regE_o_imm,
    input  regE_o_load_store_info,
    input  regE_o_stall_cnt,
    input  regE_o_bubble_cnt,
    input  regE_o_issue_cnt
  );

  modport slave (
    input  ctrl_i_regE_stall,
    input  ctrl_i_regE_bubble,
    input  decode_i_valid,
    input  decode_i_pc,
    input  decode_i_instr,
    input  decode_i_rs1,
    input  decode_i_rs2,
    input  decode_i_rd,
    input  decode_i_reg_wen,
    input  decode_i_imm,
    input  decode_i_load_store_info,
    output regE_o_valid,
    output regE_o_pc,
    output regE_o_instr,
    output regE_o_rs1,
    output regE_o_rs2,
    output regE_o_rd,
    output regE_o_reg_wen,
    output regE_o_imm,
    output regE_o_load_store_info,
    output regE_o_stall_cnt,
    output regE_o_bubble_cnt,
    output regE_o_issue_cnt
  );

endinterface

// File: rtl/pipe_reg_e_perf_counter.sv
// Wrapping event counter with synchronous active-high clear.
module pipe_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (inc) cnt <= cnt + ONE;
  end

endmodule

// File: rtl/pipe_reg_e.sv
// Decode->execute pipeline register with stall hold and NOP bubble.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_reg_e
  import pipe_reg_e_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_ENC,
  parameter int          CNT_W     = 32
) (
  input logic          clk,
  input logic          rst,
  pipe_reg_e_if.slave  bus
);

  upd_e upd;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic            wen_q;
  logic [XLEN-1:0] imm_q;
  logic [7:0]      lsi_q;

  always_comb begin
    upd = upd_sel(rst,
                  bus.ctrl_i_regE_bubble,
                  bus.ctrl_i_regE_stall,
                  bus.decode_i_valid);
  end

  always_ff @(posedge clk) begin
    unique case (upd)
      UPD_NOP: begin
        valid_q <= 1'b0;
        pc_q    <= '0;
        instr_q <= NOP_INSTR;
        rs1_q   <= '0;
        rs2_q   <= '0;
        rd_q    <= '0;
        wen_q   <= 1'b0;
        imm_q   <= '0;
        lsi_q   <= '0;
      end
      UPD_LOAD: begin
        valid_q <= 1'b1;
        pc_q    <= bus.decode_i_pc;
        instr_q <= bus.decode_i_instr;
        rs1_q   <= bus.decode_i_rs1;
        rs2_q   <= bus.decode_i_rs2;
        rd_q    <= bus.decode_i_rd;
        wen_q   <= bus.decode_i_reg_wen;
        imm_q   <= bus.decode_i_imm;
        lsi_q   <= bus.decode_i_load_store_info;
      end
      default: begin
      end
    endcase
  end

  assign bus.regE_o_valid           = valid_q;
  assign bus.regE_o_pc              = pc_q;
  assign bus.regE_o_instr           = instr_q;
  assign bus.regE_o_rs1             = rs1_q;
  assign bus.regE_o_rs2             = rs2_q;
  assign bus.regE_o_rd              = rd_q;
  assign bus.regE_o_reg_wen         = wen_q;
  assign bus.regE_o_imm             = imm_q;
  assign bus.regE_o_load_store_info = lsi_q;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  logic bubble_inc;
  logic issue_inc;

  // reset clears counters inside the counter itself
  assign stall_inc  = bus.ctrl_i_regE_stall && !bus.ctrl_i_regE_bubble;
  assign bubble_inc = bus.ctrl_i_regE_bubble;
  assign issue_inc  = (upd == UPD_LOAD);

  pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (bus.regE_o_stall_cnt)
  );

  pipe_perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bubble_inc),
    .cnt (bus.regE_o_bubble_cnt)
  );

  pipe_perf_counter #(.CNT_W(CNT_W)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .inc (issue_inc),
    .cnt (bus.regE_o_issue_cnt)
  );
`else
  assign bus.regE_o_stall_cnt  = '0;
  assign bus.regE_o_bubble_cnt = '0;
  assign bus.regE_o_issue_cnt  = '0;
`endif

endmodule
